// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, receiver state type and baud divider helper
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } rx_state_t;

    function automatic int div_calc(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Head is forced to zero while empty so the output is clean after reset.
    assign o_data = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampled UART receiver with error pulses and show-ahead receive FIFO
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          rxd,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_vld,
    input  logic                          m_rdy,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV = div_calc(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    logic                 r_rxd_meta;
    logic                 r_rxd_sync;
    logic [DW-1:0]        r_div_cnt;
    logic                 w_tick;

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [SW-1:0]        r_scnt;
    logic [SW-1:0]        w_scnt_nxt;
    logic [BW-1:0]        r_bcnt;
    logic [BW-1:0]        w_bcnt_nxt;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] w_shreg_nxt;
    logic                 r_par_bit;
    logic                 w_par_nxt;
    logic                 r_armed;

    logic                 w_par_bad;
    logic                 w_push;
    logic                 w_frame_err;
    logic                 w_parity_err;
    logic                 w_overrun;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;

    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    assign w_tick = (r_div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rstn)       r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + DW'(1);
    end

    // A held break must return high before another start bit is honoured.
    always_ff @(posedge clk) begin
        if (!rstn)           r_armed <= 1'b0;
        else if (w_frame_err) r_armed <= 1'b0;
        else if (r_rxd_sync) r_armed <= 1'b1;
    end

    always_comb begin
        w_par_bad = 1'b0;
        if (PARITY == PAR_ODD)       w_par_bad = ~(^{r_shreg, r_par_bit});
        else if (PARITY == PAR_EVEN) w_par_bad = ^{r_shreg, r_par_bit};
    end

    assign w_pop = m_rdy && !w_empty;

    always_comb begin
        w_state_nxt  = r_state;
        w_scnt_nxt   = r_scnt;
        w_bcnt_nxt   = r_bcnt;
        w_shreg_nxt  = r_shreg;
        w_par_nxt    = r_par_bit;
        w_push       = 1'b0;
        w_frame_err  = 1'b0;
        w_parity_err = 1'b0;
        w_overrun    = 1'b0;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (r_armed && !r_rxd_sync) begin
                        w_state_nxt = START;
                        w_scnt_nxt  = '0;
                    end
                end
                START: begin
                    if (r_scnt == SW'(OVERSAMPLE / 2 - 1)) begin
                        w_scnt_nxt = '0;
                        w_bcnt_nxt = '0;
                        w_state_nxt = r_rxd_sync ? IDLE : DATA;
                    end else begin
                        w_scnt_nxt = r_scnt + SW'(1);
                    end
                end
                DATA: begin
                    if (r_scnt == SW'(OVERSAMPLE - 1)) begin
                        w_scnt_nxt  = '0;
                        w_shreg_nxt = {r_rxd_sync, r_shreg[DATA_BITS-1:1]};
                        if (r_bcnt == BW'(DATA_BITS - 1))
                            w_state_nxt = (PARITY != PAR_NONE) ? PAR : STOP;
                        else
                            w_bcnt_nxt = r_bcnt + BW'(1);
                    end else begin
                        w_scnt_nxt = r_scnt + SW'(1);
                    end
                end
                PAR: begin
                    if (r_scnt == SW'(OVERSAMPLE - 1)) begin
                        w_scnt_nxt  = '0;
                        w_par_nxt   = r_rxd_sync;
                        w_state_nxt = STOP;
                    end else begin
                        w_scnt_nxt = r_scnt + SW'(1);
                    end
                end
                STOP: begin
                    if (r_scnt == SW'(OVERSAMPLE - 1)) begin
                        w_scnt_nxt  = '0;
                        w_state_nxt = IDLE;
                        if (!r_rxd_sync)          w_frame_err  = 1'b1;
                        else if (w_par_bad)       w_parity_err = 1'b1;
                        else if (w_full && !w_pop) w_overrun   = 1'b1;
                        else                      w_push       = 1'b1;
                    end else begin
                        w_scnt_nxt = r_scnt + SW'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_scnt       <= '0;
            r_bcnt       <= '0;
            r_shreg      <= '0;
            r_par_bit    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_scnt       <= w_scnt_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_shreg      <= w_shreg_nxt;
            r_par_bit    <= w_par_nxt;
            r_frame_err  <= w_frame_err;
            r_parity_err <= w_parity_err;
            r_overrun    <= w_overrun;
        end
    end

    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign m_vld      = !w_empty;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_data  (r_shreg),
        .i_pop   (m_rdy),
        .o_data  (m_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo with a queue-based reference model
module tb_uart_rx_fifo;

    localparam int CLK_HZ   = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int DEPTH    = 16;
    localparam int DIV      = CLK_HZ / (BAUD * OS);
    localparam int BIT_CLKS = CLK_HZ / BAUD;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          clk    = 1'b0;
    logic          rstn   = 1'b0;
    logic          rxd0   = 1'b1;
    logic          rxd2   = 1'b1;
    logic          m_rdy0 = 1'b0;
    logic          m_rdy2 = 1'b0;
    logic [DB-1:0] m_data0, m_data2;
    logic          m_vld0, m_vld2;
    logic          frame_err0, frame_err2;
    logic          parity_err0, parity_err2;
    logic          overrun0, overrun2;
    logic [CW-1:0] cnt0, cnt2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int p0  = 0;

    logic [7:0] got0[$];
    logic [7:0] got2[$];
    int fe0 = 0, pe0 = 0, ov0 = 0;
    int fe2 = 0, pe2 = 0, ov2 = 0;

    uart_rx_fifo #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
        .DATA_BITS(DB), .PARITY(0), .FIFO_DEPTH(DEPTH)
    ) u_dut0 (
        .clk(clk), .rstn(rstn), .rxd(rxd0),
        .m_data(m_data0), .m_vld(m_vld0), .m_rdy(m_rdy0),
        .frame_err(frame_err0), .parity_err(parity_err0), .overrun(overrun0),
        .fifo_count(cnt0)
    );

    uart_rx_fifo #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
        .DATA_BITS(DB), .PARITY(2), .FIFO_DEPTH(DEPTH)
    ) u_dut2 (
        .clk(clk), .rstn(rstn), .rxd(rxd2),
        .m_data(m_data2), .m_vld(m_vld2), .m_rdy(m_rdy2),
        .frame_err(frame_err2), .parity_err(parity_err2), .overrun(overrun2),
        .fifo_count(cnt2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (m_vld0 && m_rdy0) got0.push_back(m_data0);
            if (m_vld2 && m_rdy2) got2.push_back(m_data2);
            if (frame_err0)  fe0++;
            if (parity_err0) pe0++;
            if (overrun0)    ov0++;
            if (frame_err2)  fe2++;
            if (parity_err2) pe2++;
            if (overrun2)    ov2++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rxd0 = v;
        else          rxd2 = v;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input int pbit, input logic stop);
        @(posedge clk);
        #1;
        drive(sel, 1'b0);
        wait_clks(BIT_CLKS);
        for (int i = 0; i < DB; i++) begin
            drive(sel, d[i]);
            wait_clks(BIT_CLKS);
        end
        if (pbit >= 0) begin
            drive(sel, pbit[0]);
            wait_clks(BIT_CLKS);
        end
        drive(sel, stop);
        wait_clks(BIT_CLKS);
    endtask

    task automatic release_reset;
        rstn = 1'b1;
        p0   = cyc + 1;
    endtask

    task automatic test_reset;
        logic [16:0] outs0, outs2;
        rstn = 1'b0;
        wait_clks(4);
        outs0 = {m_vld0, m_data0, frame_err0, parity_err0, overrun0, cnt0};
        outs2 = {m_vld2, m_data2, frame_err2, parity_err2, overrun2, cnt2};
        n_checks++;
        if (outs0 !== '0) begin n_errors++; $display("FAIL rst_in_dut0 got=%h exp=0", outs0); end
        n_checks++;
        if (outs2 !== '0) begin n_errors++; $display("FAIL rst_in_dut2 got=%h exp=0", outs2); end
        release_reset();
        wait_clks(20);
        outs0 = {m_vld0, m_data0, frame_err0, parity_err0, overrun0, cnt0};
        n_checks++;
        if (outs0 !== '0) begin n_errors++; $display("FAIL rst_after_dut0 got=%h exp=0", outs0); end
    endtask

    task automatic test_single;
        int f, p, o;
        f = fe0; p = pe0; o = ov0;
        m_rdy0 = 1'b1;
        got0.delete();
        send_frame(0, 8'hA5, -1, 1'b1);
        wait_clks(20);
        n_checks++;
        if (got0.size() !== 1) begin n_errors++; $display("FAIL single_count got=%0d exp=1", got0.size()); end
        else begin
            n_checks++;
            if (got0[0] !== 8'hA5) begin n_errors++; $display("FAIL single_data got=%h exp=a5", got0[0]); end
        end
        n_checks++;
        if ((fe0 - f) + (pe0 - p) + (ov0 - o) !== 0) begin
            n_errors++; $display("FAIL single_err got=%0d exp=0", (fe0 - f) + (pe0 - p) + (ov0 - o));
        end
    endtask

    task automatic test_parity;
        int p;
        p = pe2;
        m_rdy2 = 1'b1;
        got2.delete();
        send_frame(2, 8'h03, 0, 1'b1);
        wait_clks(20);
        n_checks++;
        if (got2.size() !== 1 || pe2 !== p) begin
            n_errors++; $display("FAIL par_good got=%0d/%0d exp=1/0", got2.size(), pe2 - p);
        end else begin
            n_checks++;
            if (got2[0] !== 8'h03) begin n_errors++; $display("FAIL par_good_data got=%h exp=03", got2[0]); end
        end
        send_frame(2, 8'h03, 1, 1'b1);
        wait_clks(20);
        n_checks++;
        if (pe2 - p !== 1) begin n_errors++; $display("FAIL par_bad_pulse got=%0d exp=1", pe2 - p); end
        n_checks++;
        if (got2.size() !== 1 || cnt2 !== '0) begin
            n_errors++; $display("FAIL par_bad_drop got=%0d cnt=%0d exp=1 cnt=0", got2.size(), cnt2);
        end
    endtask

    task automatic test_break;
        int f;
        f = fe0;
        m_rdy0 = 1'b1;
        got0.delete();
        send_frame(0, 8'h55, -1, 1'b0);
        wait_clks(2000);
        n_checks++;
        if (fe0 - f !== 1) begin n_errors++; $display("FAIL break_frame_err got=%0d exp=1", fe0 - f); end
        n_checks++;
        if (got0.size() !== 0 || cnt0 !== '0) begin
            n_errors++; $display("FAIL break_no_byte got=%0d exp=0", got0.size());
        end
        rxd0 = 1'b1;
        wait_clks(100);
        send_frame(0, 8'h12, -1, 1'b1);
        wait_clks(20);
        n_checks++;
        if (got0.size() !== 1) begin n_errors++; $display("FAIL break_recover_count got=%0d exp=1", got0.size()); end
        else begin
            n_checks++;
            if (got0[0] !== 8'h12) begin n_errors++; $display("FAIL break_recover_data got=%h exp=12", got0[0]); end
        end
        n_checks++;
        if (fe0 - f !== 1) begin n_errors++; $display("FAIL break_once got=%0d exp=1", fe0 - f); end
    endtask

    task automatic test_random;
        logic [7:0] exp0[$];
        logic [7:0] exp2[$];
        logic [7:0] d;
        logic       pb;
        int         p, pe_exp;
        p = pe2;
        pe_exp = 0;
        m_rdy0 = 1'b1;
        m_rdy2 = 1'b1;
        got0.delete();
        got2.delete();
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            exp0.push_back(d);
            send_frame(0, d, -1, 1'b1);
            wait_clks($urandom_range(1, 50));
            d  = 8'($urandom);
            pb = 1'($urandom_range(0, 1));
            if (((^d) ^ pb) == 1'b0) exp2.push_back(d);
            else pe_exp++;
            send_frame(2, d, int'(pb), 1'b1);
            wait_clks($urandom_range(1, 50));
        end
        wait_clks(20);
        n_checks++;
        if (got0.size() !== exp0.size()) begin
            n_errors++; $display("FAIL rand0_count got=%0d exp=%0d", got0.size(), exp0.size());
        end else begin
            for (int i = 0; i < exp0.size(); i++) begin
                n_checks++;
                if (got0[i] !== exp0[i]) begin n_errors++; $display("FAIL rand0_data[%0d] got=%h exp=%h", i, got0[i], exp0[i]); end
            end
        end
        n_checks++;
        if (got2.size() !== exp2.size() || pe2 - p !== pe_exp) begin
            n_errors++;
            $display("FAIL rand2_count got=%0d/%0d exp=%0d/%0d", got2.size(), pe2 - p, exp2.size(), pe_exp);
        end else begin
            for (int i = 0; i < exp2.size(); i++) begin
                n_checks++;
                if (got2[i] !== exp2[i]) begin n_errors++; $display("FAIL rand2_data[%0d] got=%h exp=%h", i, got2[i], exp2[i]); end
            end
        end
    endtask

    task automatic test_overrun_and_full_pop;
        logic [7:0] mq[$];
        logic [7:0] exp_out[$];
        int         o, exp_ov;
        o = ov0;
        exp_ov = 0;
        m_rdy0 = 1'b0;
        got0.delete();
        for (int i = 0; i <= DEPTH; i++) begin
            if (mq.size() == DEPTH) exp_ov++;
            else mq.push_back(8'(i));
            send_frame(0, 8'(i), -1, 1'b1);
            wait_clks(20);
        end
        n_checks++;
        if (cnt0 !== CW'(mq.size())) begin n_errors++; $display("FAIL ovr_count got=%0d exp=%0d", cnt0, mq.size()); end
        n_checks++;
        if (ov0 - o !== exp_ov) begin n_errors++; $display("FAIL ovr_pulse got=%0d exp=%0d", ov0 - o, exp_ov); end
        wait_clks(50);
        n_checks++;
        if (m_vld0 !== 1'b1 || m_data0 !== mq[0]) begin
            n_errors++; $display("FAIL ovr_head got=%b/%h exp=1/%h", m_vld0, m_data0, mq[0]);
        end
        fork
            send_frame(0, 8'h20, -1, 1'b1);
            begin
                int e, t, s;
                @(posedge clk);
                #1;
                e = cyc;
                t = e + 3;
                while (((t - p0 - (DIV - 1)) % DIV) != 0) t++;
                s = t + (OS / 2) * DIV + (DB + 1) * OS * DIV;
                wait_clks(s - 1 - e);
                m_rdy0 = 1'b1;
                wait_clks(1);
                m_rdy0 = 1'b0;
            end
        join
        exp_out.push_back(mq.pop_front());
        mq.push_back(8'h20);
        wait_clks(20);
        n_checks++;
        if (ov0 - o !== exp_ov) begin n_errors++; $display("FAIL fullpop_overrun got=%0d exp=%0d", ov0 - o, exp_ov); end
        n_checks++;
        if (cnt0 !== CW'(DEPTH)) begin n_errors++; $display("FAIL fullpop_count got=%0d exp=%0d", cnt0, DEPTH); end
        while (mq.size() > 0) exp_out.push_back(mq.pop_front());
        m_rdy0 = 1'b1;
        wait_clks(40);
        n_checks++;
        if (got0.size() !== exp_out.size()) begin
            n_errors++; $display("FAIL drain_count got=%0d exp=%0d", got0.size(), exp_out.size());
        end else begin
            for (int i = 0; i < exp_out.size(); i++) begin
                n_checks++;
                if (got0[i] !== exp_out[i]) begin n_errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, got0[i], exp_out[i]); end
            end
        end
        n_checks++;
        if (cnt0 !== '0 || m_vld0 !== 1'b0) begin n_errors++; $display("FAIL drain_empty got=%0d exp=0", cnt0); end
    endtask

    task automatic test_glitch_and_reset;
        int f, p, o;
        logic [16:0] outs0;
        f = fe0; p = pe0; o = ov0;
        m_rdy0 = 1'b1;
        got0.delete();
        rxd0 = 1'b0;
        wait_clks(40);
        rxd0 = 1'b1;
        wait_clks(300);
        n_checks++;
        if (got0.size() !== 0 || cnt0 !== '0 || (fe0 - f) + (pe0 - p) + (ov0 - o) !== 0) begin
            n_errors++; $display("FAIL glitch_reject got=%0d bytes exp=0", got0.size());
        end
        m_rdy0 = 1'b0;
        send_frame(0, 8'h99, -1, 1'b1);
        wait_clks(20);
        n_checks++;
        if (cnt0 !== CW'(1)) begin n_errors++; $display("FAIL prereset_count got=%0d exp=1", cnt0); end
        fork
            send_frame(0, 8'h7E, -1, 1'b1);
            begin
                wait_clks(700);
                rstn = 1'b0;
                wait_clks(3);
                outs0 = {m_vld0, m_data0, frame_err0, parity_err0, overrun0, cnt0};
                n_checks++;
                if (outs0 !== '0) begin n_errors++; $display("FAIL midframe_rst_outs got=%h exp=0", outs0); end
            end
        join
        wait_clks(10);
        release_reset();
        wait_clks(20);
        m_rdy0 = 1'b1;
        wait_clks(20);
        n_checks++;
        if (got0.size() !== 0) begin n_errors++; $display("FAIL midframe_no_byte got=%0d exp=0", got0.size()); end
        send_frame(0, 8'h3C, -1, 1'b1);
        wait_clks(20);
        n_checks++;
        if (got0.size() !== 1) begin n_errors++; $display("FAIL postrst_count got=%0d exp=1", got0.size()); end
        else begin
            n_checks++;
            if (got0[0] !== 8'h3C) begin n_errors++; $display("FAIL postrst_data got=%h exp=3c", got0[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_break();
        test_random();
        test_overrun_and_full_pop();
        test_glitch_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
